// File: rtl/iscas_bist_ctrl.sv
// BIST sequencer for a wrapped ISCAS89 core: flush, LFSR patterns, MISR compaction,
// and a golden-signature compare, with functional bypass when no test is running.
module iscas_bist_ctrl #(
  parameter int                 PI_W      = 3,
  parameter int                 PO_W      = 6,
  parameter int                 LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 8'h01,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8,
  parameter int                 MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_TAPS = 16'hB400,
  parameter int                 N_PAT     = 255,
  parameter int                 FLUSH_CYC = 8,
  parameter logic [MISR_W-1:0]  GOLDEN    = 16'h0000
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [PI_W-1:0]   FUNC_PI,
  input  logic [PO_W-1:0]   CORE_PO,
  output logic [PI_W-1:0]   CORE_PI,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIGNATURE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_RUN    = 3'd2,
    S_CMP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Terminal counts; FLUSH is never entered when FLUSH_CYC is zero.
  localparam logic [15:0] FLUSH_LAST = (FLUSH_CYC > 0) ? 16'(FLUSH_CYC - 1) : 16'd0;
  localparam logic [15:0] PAT_LAST   = 16'(N_PAT - 1);

  state_t              r_state;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [MISR_W-1:0]   r_misr;
  logic [15:0]         r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  state_t              w_state_next;
  logic [LFSR_W-1:0]   w_lfsr_next;
  logic [MISR_W-1:0]   w_misr_next;
  logic [15:0]         w_cnt_next;
  logic                w_done_next;
  logic                w_pass_next;
  logic                w_busy_next;
  logic [PI_W-1:0]     w_core_pi;
  logic [MISR_W-1:0]   w_po_ext;
  logic                w_in_test;

  assign w_po_ext  = MISR_W'(CORE_PO);
  assign w_in_test = (r_state == S_FLUSH) || (r_state == S_RUN) || (r_state == S_CMP);

  always_comb begin
    w_state_next = r_state;
    w_lfsr_next  = r_lfsr;
    w_misr_next  = r_misr;
    w_cnt_next   = r_cnt;
    w_done_next  = r_done;
    w_pass_next  = r_pass;
    w_core_pi    = '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_core_pi = FUNC_PI;
        if (START) begin
          w_lfsr_next  = LFSR_SEED;
          w_misr_next  = '0;
          w_cnt_next   = '0;
          w_done_next  = 1'b0;
          w_pass_next  = 1'b0;
          w_state_next = (FLUSH_CYC == 0) ? S_RUN : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_cnt == FLUSH_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_RUN;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_RUN: begin
        w_core_pi   = r_lfsr[PI_W-1:0];
        w_lfsr_next = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
        w_misr_next = {r_misr[MISR_W-2:0], ^(r_misr & MISR_TAPS)} ^ w_po_ext;
        if (r_cnt == PAT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_CMP;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_CMP: begin
        w_pass_next  = (r_misr == GOLDEN);
        w_done_next  = 1'b1;
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort overrides any in-test update but leaves the pattern and signature registers frozen.
    if (ABORT && w_in_test) begin
      w_state_next = S_IDLE;
      w_lfsr_next  = r_lfsr;
      w_misr_next  = r_misr;
      w_cnt_next   = '0;
      w_done_next  = 1'b0;
      w_pass_next  = 1'b0;
    end

    w_busy_next = (w_state_next == S_FLUSH) || (w_state_next == S_RUN) ||
                  (w_state_next == S_CMP);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_misr  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lfsr  <= w_lfsr_next;
      r_misr  <= w_misr_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_pass  <= w_pass_next;
    end
  end

  assign CORE_PI   = w_core_pi;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign SIGNATURE = r_misr;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Directed bench: default-parameter controller plus two single-pattern variants
// that differ only in their golden signature.
module tb_iscas_bist_ctrl;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [2:0]  FUNC_PI = 3'b101;
  logic [5:0]  CORE_PO = 6'h00;
  logic [2:0]  CORE_PI;
  logic        BUSY, DONE, PASS;
  logic [15:0] SIGNATURE;

  logic        start_bc = 1'b0;
  logic [5:0]  po_bc = 6'h01;
  logic [2:0]  pi_b, pi_c;
  logic        busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [15:0] sig_b, sig_c;

  int n_checks = 0;
  int n_err = 0;

  logic [15:0] pi_q[$];
  logic [15:0] sig_q[$];

  iscas_bist_ctrl u_dut (
    .CK(CK), .RST(RST), .START(START), .ABORT(ABORT), .FUNC_PI(FUNC_PI),
    .CORE_PO(CORE_PO), .CORE_PI(CORE_PI), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS), .SIGNATURE(SIGNATURE)
  );

  iscas_bist_ctrl #(.N_PAT(1), .FLUSH_CYC(0)) u_dut_b (
    .CK(CK), .RST(RST), .START(start_bc), .ABORT(1'b0), .FUNC_PI(FUNC_PI),
    .CORE_PO(po_bc), .CORE_PI(pi_b), .BUSY(busy_b), .DONE(done_b),
    .PASS(pass_b), .SIGNATURE(sig_b)
  );

  iscas_bist_ctrl #(.N_PAT(1), .FLUSH_CYC(0), .GOLDEN(16'h0001)) u_dut_c (
    .CK(CK), .RST(RST), .START(start_bc), .ABORT(1'b0), .FUNC_PI(FUNC_PI),
    .CORE_PO(po_bc), .CORE_PI(pi_c), .BUSY(busy_c), .DONE(done_c),
    .PASS(pass_c), .SIGNATURE(sig_c)
  );

  initial forever #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] po);
    return {m[14:0], ^(m & 16'hB400)} ^ {10'b0, po};
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  // Full default run from IDLE/DONE_S; optionally random outputs, START+ABORT at
  // launch and extra START pulses mid-run that must not disturb the sequence.
  task automatic run_full(input bit rand_po, input bit extra_starts);
    logic [7:0]  l;
    logic [15:0] m;
    logic [5:0]  po;
    START = 1'b1;
    ABORT = extra_starts;
    CORE_PO = rand_po ? 6'($urandom) : 6'h00;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    check("busy_rise", BUSY, 1);
    check("done_clr", DONE, 0);
    check("pass_clr", PASS, 0);
    check("sig_clr", SIGNATURE, 0);
    FUNC_PI = 3'b111;
    for (int i = 0; i < 8; i++) begin
      check("flush_pi", CORE_PI, 0);
      check("flush_sig", SIGNATURE, 0);
      if (rand_po) CORE_PO = 6'($urandom);
      tick();
    end
    l = 8'h01;
    m = 16'h0000;
    for (int p = 0; p < 255; p++) begin
      pi_q.push_back({13'b0, l[2:0]});
      check("run_pi", CORE_PI, pi_q.pop_front());
      check("run_done_low", DONE, 0);
      po = rand_po ? 6'($urandom) : 6'h00;
      CORE_PO = po;
      m = misr_step(m, po);
      l = lfsr_step(l);
      START = (extra_starts && (p % 50 == 7)) ? 1'b1 : 1'b0;
      if (p == 254) sig_q.push_back(m);
      tick();
    end
    START = 1'b0;
    check("cmp_busy", BUSY, 1);
    check("cmp_done_low", DONE, 0);
    check("cmp_pi", CORE_PI, 0);
    CORE_PO = rand_po ? 6'($urandom) : 6'h00;
    tick();
    check("done_at_264", DONE, 1);
    check("done_busy", BUSY, 0);
    check("done_sig", SIGNATURE, sig_q.pop_front());
    check("done_pass", PASS, (m == 16'h0000) ? 1 : 0);
    check("done_bypass", CORE_PI, FUNC_PI);
  endtask

  initial begin
    logic [15:0] m;
    logic [5:0]  po;

    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_pass", PASS, 0);
    check("rst_sig", SIGNATURE, 0);
    check("idle_bypass", CORE_PI, 3'b101);

    // Single-pattern variants: no flush, one MISR update of 6'h01.
    start_bc = 1'b1;
    tick();
    start_bc = 1'b0;
    check("b_run_pi", pi_b, 3'b001);
    check("b_busy", busy_b, 1);
    tick();
    check("b_sig", sig_b, 16'h0001);
    check("c_sig", sig_c, 16'h0001);
    check("b_cmp_done_low", done_b, 0);
    tick();
    check("b_done", done_b, 1);
    check("b_pass", pass_b, 0);
    check("c_done", done_c, 1);
    check("c_pass", pass_c, 1);

    // Zero outputs: signature must stay zero and match the zero golden value.
    run_full(1'b0, 1'b0);

    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abort_in_done_done", DONE, 1);
    check("abort_in_done_pass", PASS, 1);
    check("abort_in_done_busy", BUSY, 0);

    // Random outputs, START+ABORT together at launch, stray START pulses mid-run.
    run_full(1'b1, 1'b1);

    // Abort ten patterns into RUN.
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (8) tick();
    m = 16'h0000;
    for (int p = 0; p < 10; p++) begin
      po = 6'($urandom);
      CORE_PO = po;
      m = misr_step(m, po);
      tick();
    end
    check("pre_abort_busy", BUSY, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    FUNC_PI = 3'b011;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_pass", PASS, 0);
    check("abort_sig_held", SIGNATURE, m);
    check("abort_bypass", CORE_PI, 3'b011);
    tick();
    check("abort_stays_idle", BUSY, 0);

    // Asynchronous reset in the middle of RUN.
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (8) tick();
    CORE_PO = 6'h3F;
    m = 16'h0000;
    for (int p = 0; p < 5; p++) begin
      m = misr_step(m, 6'h3F);
      tick();
    end
    check("pre_rst_sig", SIGNATURE, m);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_busy", BUSY, 0);
    check("async_rst_done", DONE, 0);
    check("async_rst_pass", PASS, 0);
    check("async_rst_sig", SIGNATURE, 0);
    RST = 1'b0;
    FUNC_PI = 3'b110;
    tick();
    check("post_rst_bypass", CORE_PI, 3'b110);
    check("post_rst_busy", BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
